parallel_to_serial: RTL
=======================

Name: parallel_to_serial

Overview:
Transmit-side counterpart of the team's WIDTH-bit serial receiver. Accepts a parallel word through a valid/ready load handshake and shifts it out MSB-first, one bit per clk. serial_valid is driven as the receiver's enable, so after WIDTH valid bits the receiver holds the original word. Sits between a word-producing datapath and a one-bit serial link; supports back-to-back frames and sink back-pressure.

Parameters:
WIDTH, 8, data bits per frame; legal range 2..64.

Ports:
clk  input  1  clock, all logic on rising edge
reset  input  1  asynchronous, active-high reset
load_valid  input  1  load_data is valid this cycle
load_ready  output  1  block can accept a word this cycle
load_data  input  WIDTH  word to transmit, bit WIDTH-1 sent first
stall  input  1  sink back-pressure: hold the current bit, no advance
serial_out  output  1  current serial bit
serial_valid  output  1  serial_out is a valid bit this cycle (receiver enable)
last  output  1  current bit is the final bit of the frame
busy  output  1  frame in progress (state SHIFT)

Behaviour:
- Reset is asynchronous and active-high on clk-domain state only. It clears state to IDLE, shift register and bit counter to 0. All outputs read 0 except load_ready, which reads 1 once reset deasserts.
- Reset during a frame aborts it immediately. No partial bits are emitted afterwards.
- States are IDLE and SHIFT.
- IDLE: load_ready=1, serial_valid=0, serial_out=0, last=0, busy=0.
  - On load_valid&load_ready at edge N: capture load_data into the shift register, count<=0, state<=SHIFT.
  - First bit (load_data[WIDTH-1]) is on serial_out in the cycle after edge N. Latency is 1 cycle.
- SHIFT:
  - serial_out = shift_reg[WIDTH-1]. serial_valid = ~stall. busy=1.
  - last = (count==FRAME_LEN-1). FRAME_LEN is WIDTH, or WIDTH+1 with parity enabled.
  - Each edge with ~stall: shift left by 1 (fill 0) and count++.
- stall=1: shift register, count and last hold; serial_valid=0; serial_out holds its value.
- load_ready = IDLE | (SHIFT & last & ~stall).
- End of frame, on the last-bit edge with ~stall:
  - If a handshake occurs on that edge, load the new word, count<=0, stay in SHIFT. There is no bubble between frames.
  - Otherwise state<=IDLE.
- load_valid while load_ready=0 is ignored. load_data is not sampled, and the source must hold it.
- The counter is sized from the package constant and never wraps mid-frame.
- Outputs are decoded combinationally from registered state only. There is no combinational path from load_valid or load_data to any output.
- stall affects serial_valid combinationally.

Optional Feature:
Macro: P2S_PARITY_EN
- Defined: FRAME_LEN=WIDTH+1.
  - Even parity, the XOR of the captured word, is computed at load into a 1-bit register.
  - After the WIDTH data bits, one extra SHIFT cycle drives the parity bit on serial_out with serial_valid=1 and last=1.
  - Back-to-back and stall rules apply to the parity cycle unchanged.
- Undefined: FRAME_LEN=WIDTH, and no parity register or logic exists.

Decomposition:
- Package p2s_pkg holds:
  - the state typedef, an enum {IDLE, SHIFT};
  - the function returning FRAME_LEN for a given WIDTH, conditional on the macro;
  - the counter-width constant, $clog2(WIDTH+2).
- No sub-module. Parity is a single reduction-XOR and is inlined.

Test Plan:
- WIDTH=8, load 0xA5 at cycle 0, stall=0 -> serial_out 1,0,1,0,0,1,0,1 on cycles 1-8 with serial_valid=1; last only on cycle 8; load_ready=1 on cycle 8; IDLE on cycle 9.
- Back-to-back 0xA5 then 0x3C, load_valid held -> 16 consecutive valid bits ending 0,0,1,1,1,1,0,0; no gap; last on cycles 8 and 16.
- 0xA5 with stall=1 during cycles 3-5 -> serial_valid=0 and bit held on those cycles; frame completes on cycle 11; bit sequence unchanged.
- Reset asserted at cycle 4 of 0xFF -> all outputs 0 immediately; after release, load_ready=1; next load 0x81 transmits cleanly.
- load_valid pulsed with 0x00 on cycles 2-6 during a 0xA5 frame -> ignored; 0xA5 stream intact.
- With P2S_PARITY_EN: 0xA5 -> 9 bits with parity 0 on cycle 9; 0x07 -> parity 1; last only on the parity bit.
- Loopback into the existing receiver -> its captured word equals the transmitted word for random data.

Source files
------------

// File: rtl/parallel_to_serial_pkg.sv
// ============================================================================
// Module  : p2s_pkg
// Purpose : Shared types and sizing helpers for parallel_to_serial.
//           Macro P2S_PARITY_EN appends an even-parity bit to every frame.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package p2s_pkg;

  localparam int unsigned P2S_WIDTH_DEFAULT = 8;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } p2s_state_e;

  // Serial bits per frame, including the parity bit when enabled.
  function automatic int unsigned p2s_frame_len(input int unsigned width);
`ifdef P2S_PARITY_EN
    return width + 1;
`else
    return width;
`endif
  endfunction

  // Bit counter width; covers every index of the longest frame.
  function automatic int unsigned p2s_cnt_width(input int unsigned width);
    return $clog2(width + 2);
  endfunction

endpackage

`default_nettype wire

// File: rtl/parallel_to_serial.sv
// ============================================================================
// Module  : parallel_to_serial
// Purpose : Loads a WIDTH-bit word over a valid/ready handshake and shifts it
//           out MSB-first with stall back-pressure and gapless back-to-back
//           frames. Macro P2S_PARITY_EN adds a trailing even-parity bit.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module parallel_to_serial
  import p2s_pkg::*;
#(
  parameter int unsigned WIDTH = P2S_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] load_data,
  input  logic             stall,
  output logic             serial_out,
  output logic             serial_valid,
  output logic             last,
  output logic             busy
);

  localparam int unsigned c_CNT_W     = p2s_cnt_width(WIDTH);
  localparam int unsigned c_FRAME_LEN = p2s_frame_len(WIDTH);
  localparam logic [c_CNT_W-1:0] c_LAST_IDX = c_CNT_W'(c_FRAME_LEN - 1);

  p2s_state_e         r_state, w_state_nxt;
  logic [WIDTH-1:0]   r_shift, w_shift_nxt;
  logic [c_CNT_W-1:0] r_count, w_count_nxt;

  logic w_in_shift;
  logic w_last;
  logic w_accept;
  logic w_load;
  logic w_data_bit;

  assign w_in_shift = (r_state == SHIFT);
  assign w_last     = w_in_shift && (r_count == c_LAST_IDX);
  assign w_accept   = load_valid && load_ready;

`ifdef P2S_PARITY_EN
  localparam logic [c_CNT_W-1:0] c_PAR_IDX = c_CNT_W'(WIDTH);

  logic r_parity;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_parity <= 1'b0;
    end else if (w_load) begin
      r_parity <= ^load_data;
    end
  end

  // Data bits are exhausted once the count reaches WIDTH; the parity bit follows.
  assign w_data_bit = (r_count == c_PAR_IDX) ? r_parity : r_shift[WIDTH-1];
`else
  assign w_data_bit = r_shift[WIDTH-1];
`endif

  // Reset gates ready so nothing reads as accepting while reset is held.
  assign load_ready   = ~reset & (~w_in_shift | (w_last & ~stall));
  assign busy         = w_in_shift;
  assign last         = w_last;
  assign serial_valid = w_in_shift & ~stall;
  assign serial_out   = w_in_shift & w_data_bit;

  always_comb begin
    w_state_nxt = r_state;
    w_shift_nxt = r_shift;
    w_count_nxt = r_count;
    w_load      = 1'b0;

    case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_load = 1'b1;
        end
      end
      SHIFT: begin
        if (!stall) begin
          if (w_last) begin
            if (w_accept) begin
              w_load = 1'b1;
            end else begin
              w_state_nxt = IDLE;
              w_shift_nxt = '0;
              w_count_nxt = '0;
            end
          end else begin
            w_shift_nxt = {r_shift[WIDTH-2:0], 1'b0};
            w_count_nxt = r_count + c_CNT_W'(1);
          end
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_shift_nxt = '0;
        w_count_nxt = '0;
      end
    endcase

    if (w_load) begin
      w_state_nxt = SHIFT;
      w_shift_nxt = load_data;
      w_count_nxt = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_shift <= '0;
      r_count <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_shift <= w_shift_nxt;
      r_count <= w_count_nxt;
    end
  end

endmodule

`default_nettype wire
